sm_clk_gen: RTL and testbench



---
 rtl/sm_clk_gen_pkg.sv | 17 +
 rtl/sm_clk_gen_if.sv | 24 ++
 rtl/sm_clk_phase_len.sv | 36 +++
 rtl/sm_clk_gen.sv | 117 +++++++++++
 tb/tb_sm_clk_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm_clk_gen_pkg.sv
// Shared encodings for the programmable clock generator: input modes and FSM states.
package sm_clk_gen_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t MODE_POW2 = 2'b00;
  localparam mode_t MODE_DIV  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;
  localparam mode_t MODE_STOP = 2'b11;

  localparam state_t ST_STOP = 2'b00;
  localparam state_t ST_WAIT = 2'b01;
  localparam state_t ST_HIGH = 2'b10;
  localparam state_t ST_LOW  = 2'b11;

endpackage

// File: rtl/sm_clk_gen_if.sv
// Control inputs and generated-clock outputs of sm_clk_gen, bundled for drop-in hookup.
interface sm_clk_gen_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 4
);
  logic             enable;
  logic [1:0]       mode;
  logic [SEL_W-1:0] devide;
  logic [WIDTH-1:0] period;
  logic             step;
  logic             clkOut;
  logic             tick;
  logic             busy;

  modport master (
    output enable, mode, devide, period, step,
    input  clkOut, tick, busy
  );

  modport slave (
    input  enable, mode, devide, period, step,
    output clkOut, tick, busy
  );
endinterface

// File: rtl/sm_clk_phase_len.sv
// HIGH/LOW phase lengths derived from the latched mode, exponent offset and period.
module sm_clk_phase_len
  import sm_clk_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [1:0]       cur_mode,
  input  logic [SEL_W-1:0] cur_devide,
  input  logic [WIDTH-1:0] cur_period,
  output logic [WIDTH-1:0] lh,
  output logic [WIDTH-1:0] ll
);

  logic [31:0]      exp_raw;
  logic [31:0]      exp_sat;
  logic [WIDTH-1:0] pow_len;
  logic [WIDTH-1:0] n_len;

  always_comb begin
    exp_raw = SHIFT + 32'(cur_devide);
    // Saturating the exponent keeps the one-hot shift inside WIDTH bits.
    exp_sat = (exp_raw > (WIDTH - 1)) ? (WIDTH - 1) : exp_raw;
    pow_len = {{(WIDTH-1){1'b0}}, 1'b1} << exp_sat;
    n_len   = (cur_period < WIDTH'(2)) ? WIDTH'(2) : cur_period;

    lh = pow_len;
    ll = pow_len;
    if (cur_mode != MODE_POW2) begin
      lh = n_len - (n_len >> 1);
      ll = n_len >> 1;
    end
  end

endmodule

// File: rtl/sm_clk_gen.sv
// Programmable clock generator: registered glitch-free clkOut with a rising-edge tick strobe.
module sm_clk_gen
  import sm_clk_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic        clkIn,
  input  logic        rst_n,
  sm_clk_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [SEL_W-1:0] cur_devide_q, cur_devide_d;
  logic [WIDTH-1:0] cur_period_q, cur_period_d;
  logic             step_prev_q, step_prev_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] lh;
  logic [WIDTH-1:0] ll;
  logic             boundary;
  logic             step_rise;

  sm_clk_phase_len #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .SEL_W (SEL_W)
  ) u_phase_len (
    .cur_mode   (cur_mode_q),
    .cur_devide (cur_devide_q),
    .cur_period (cur_period_q),
    .lh         (lh),
    .ll         (ll)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_mode_d   = cur_mode_q;
    cur_devide_d = cur_devide_q;
    cur_period_d = cur_period_q;
    step_prev_d  = bus.step;
    step_rise    = bus.step & ~step_prev_q;
    boundary     = 1'b0;

    case (state_q)
      ST_STOP, ST_WAIT: boundary = 1'b1;
      ST_HIGH: begin
        if (cnt_q == lh - WIDTH'(1)) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == ll - WIDTH'(1)) boundary = 1'b1;
        else                         cnt_d = cnt_q + WIDTH'(1);
      end
      default: state_d = ST_STOP;
    endcase

    // Inputs are only sampled here, so a running period always finishes at its old length.
    if (boundary) begin
      cur_mode_d   = bus.mode;
      cur_devide_d = bus.devide;
      cur_period_d = bus.period;
      cnt_d        = '0;
      if (!bus.enable || bus.mode == MODE_STOP) begin
        state_d = ST_STOP;
      end else if (bus.mode == MODE_STEP) begin
        state_d = (state_q == ST_WAIT && step_rise) ? ST_HIGH : ST_WAIT;
      end else begin
        state_d = ST_HIGH;
      end
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    clk_out_d = (state_d == ST_HIGH);
    busy_d    = (state_d == ST_HIGH) || (state_d == ST_LOW);
    tick_d    = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STOP;
      cnt_q        <= '0;
      cur_mode_q   <= MODE_STOP;
      cur_devide_q <= '0;
      cur_period_q <= '0;
      step_prev_q  <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_mode_q   <= cur_mode_d;
      cur_devide_q <= cur_devide_d;
      cur_period_q <= cur_period_d;
      step_prev_q  <= step_prev_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.clkOut = clk_out_q;
  assign bus.tick   = tick_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sm_clk_gen.sv
// Bench for sm_clk_gen: period-level reference model (queue of upcoming clkOut levels) plus directed scenarios.
module tb_sm_clk_gen;
  import sm_clk_gen_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHIFT = 2;
  localparam int unsigned SEL_W = 4;

  logic clkIn = 1'b0;
  logic rst_n = 1'b0;

  sm_clk_gen_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  sm_clk_gen #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .SEL_W (SEL_W)
  ) dut (
    .clkIn (clkIn),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clkIn = ~clkIn;

  int total = 0;
  int bad   = 0;
  int n_tick = 0;
  int n_high = 0;

  bit m_clk, m_tick, m_busy, m_wait, m_prev;
  bit m_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pow2_len(input int unsigned dev);
    int unsigned e;
    e = SHIFT + dev;
    if (e > WIDTH - 1) e = WIDTH - 1;
    return 32'd1 << e;
  endfunction

  task automatic mdl_reset();
    m_q.delete();
    m_clk = 0; m_tick = 0; m_busy = 0; m_wait = 0; m_prev = 0;
  endtask

  // One clkIn edge: either continue the queued period or decide at the boundary.
  task automatic mdl_step();
    int unsigned hi, lo, n;
    m_tick = 0;
    if (m_q.size() != 0) begin
      m_clk  = m_q.pop_front();
      m_busy = 1;
    end else if (!bus.enable || bus.mode == MODE_STOP) begin
      m_clk = 0; m_busy = 0; m_wait = 0;
    end else if (bus.mode == MODE_STEP && !(m_wait && bus.step && !m_prev)) begin
      m_clk = 0; m_busy = 0; m_wait = 1;
    end else begin
      if (bus.mode == MODE_POW2) begin
        hi = pow2_len(32'(bus.devide));
        lo = hi;
      end else begin
        n  = (32'(bus.period) < 2) ? 2 : 32'(bus.period);
        hi = (n + 1) / 2;
        lo = n / 2;
      end
      repeat (hi) m_q.push_back(1'b1);
      repeat (lo) m_q.push_back(1'b0);
      m_clk = m_q.pop_front();
      m_busy = 1; m_tick = 1; m_wait = 0;
    end
    m_prev = bus.step;
  endtask

  task automatic cyc(input string tag);
    mdl_step();
    @(posedge clkIn);
    #1;
    check_val(tag, 32'({bus.clkOut, bus.tick, bus.busy}), 32'({m_clk, m_tick, m_busy}));
    if (bus.tick === 1'b1) n_tick++;
    if (bus.clkOut === 1'b1) n_high++;
  endtask

  task automatic set_in(input logic en, input logic [1:0] md, input logic [SEL_W-1:0] dv,
                        input logic [WIDTH-1:0] per, input logic st);
    bus.enable = en; bus.mode = md; bus.devide = dv; bus.period = per; bus.step = st;
  endtask

  task automatic go_idle();
    bus.enable = 1'b0;
    bus.step   = 1'b0;
    repeat (20) cyc("to_idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int unsigned div_per[5] = '{5, 0, 1, 2, 7};
  int unsigned div_hi[5]  = '{3, 1, 1, 1, 4};
  int unsigned div_n[5]   = '{5, 2, 2, 2, 7};

  initial begin
    set_in(1'b0, MODE_POW2, '0, '0, 1'b0);
    mdl_reset();
    #2;
    check_val("reset_outs", 32'({bus.clkOut, bus.tick, bus.busy}), 32'd0);
    repeat (3) @(posedge clkIn);
    #1;
    check_val("reset_hold", 32'({bus.clkOut, bus.tick, bus.busy}), 32'd0);
    rst_n = 1'b1;

    n_high = 0;
    repeat (100) cyc("idle");
    check_val("idle_high", n_high, 0);

    // POW2, devide=1: 8 high / 8 low
    set_in(1'b1, MODE_POW2, 4'd1, '0, 1'b0);
    n_tick = 0; n_high = 0;
    repeat (64) cyc("pow2_d1");
    check_val("pow2_d1_ticks", n_tick, 4);
    check_val("pow2_d1_high", n_high, 32);
    go_idle();

    // exponent change inside a running period only applies to the next one
    set_in(1'b1, MODE_POW2, 4'd1, '0, 1'b0);
    cyc("mid_h1");
    cyc("mid_h2");
    bus.devide = 4'd0;
    n_tick = 0; n_high = 0;
    repeat (14) cyc("mid_rest");
    check_val("mid_old_high", n_high, 6);
    check_val("mid_old_ticks", n_tick, 0);
    n_tick = 0; n_high = 0;
    repeat (8) cyc("mid_new");
    check_val("mid_new_high", n_high, 4);
    check_val("mid_new_ticks", n_tick, 1);
    go_idle();

    foreach (div_per[i]) begin
      set_in(1'b1, MODE_DIV, '0, 16'(div_per[i]), 1'b0);
      n_tick = 0; n_high = 0;
      repeat (4 * div_n[i]) cyc("div");
      check_val("div_ticks", n_tick, 4);
      check_val("div_high", n_high, 4 * div_hi[i]);
      go_idle();
    end

    // STEP, period=4: two separated pulses
    set_in(1'b1, MODE_STEP, '0, 16'd4, 1'b0);
    repeat (3) cyc("step_wait");
    n_tick = 0; n_high = 0;
    bus.step = 1'b1; cyc("step_p1");
    bus.step = 1'b0; repeat (8) cyc("step_p1b");
    bus.step = 1'b1; cyc("step_p2");
    bus.step = 1'b0; repeat (8) cyc("step_p2b");
    check_val("step2_ticks", n_tick, 2);
    check_val("step2_high", n_high, 4);

    n_tick = 0;
    bus.step = 1'b1; repeat (50) cyc("step_held");
    bus.step = 1'b0; repeat (5) cyc("step_held_b");
    check_val("step_held_ticks", n_tick, 1);

    n_tick = 0;
    bus.step = 1'b1; cyc("step_ign_a");
    bus.step = 1'b0; cyc("step_ign_b");
    bus.step = 1'b1; cyc("step_ign_c");
    bus.step = 1'b0; repeat (8) cyc("step_ign_d");
    check_val("step_ign_ticks", n_tick, 1);
    go_idle();

    // enable dropped in the first HIGH cycle
    set_in(1'b1, MODE_DIV, '0, 16'd6, 1'b0);
    cyc("drop_h1");
    bus.enable = 1'b0;
    n_high = 0; n_tick = 0;
    repeat (8) cyc("drop_rest");
    check_val("drop_high", n_high, 2);
    check_val("drop_busy", 32'(bus.busy), 0);

    // asynchronous reset while clkOut is high
    set_in(1'b1, MODE_POW2, 4'd0, '0, 1'b0);
    cyc("rst_h1");
    cyc("rst_h2");
    check_val("rst_pre_high", 32'(bus.clkOut), 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async", 32'({bus.clkOut, bus.tick, bus.busy}), 32'd0);
    mdl_reset();
    @(posedge clkIn);
    #1;
    rst_n = 1'b1;
    n_tick = 0;
    cyc("rst_after");
    check_val("rst_restart_tick", n_tick, 1);
    repeat (10) cyc("rst_run");
    go_idle();

    // exponent saturation: 2+15 clamps to 15 -> 32768-cycle phases
    set_in(1'b1, MODE_POW2, 4'd15, '0, 1'b0);
    n_high = 0;
    repeat (32768 + 4) cyc("pow2_sat");
    check_val("pow2_sat_high", n_high, 32768);
    rst_n = 1'b0;
    mdl_reset();
    @(posedge clkIn);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus.devide = 4'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.period = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.step = ~bus.step;
      cyc("rand");
    end
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
